// File: rtl/turf_generic_seq.sv
// Sequencer between the TURF generic arbiter master side and the TURF generic bus.
// Optional hung-transaction abort is built when TURF_GEN_SEQ_TIMEOUT_EN is defined.
module turf_generic_seq #(
  parameter int          TIMEOUT      = 256,
  parameter int          IDLE_GAP     = 1,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_en_i,
  input  logic        s_wr_i,
  input  logic [27:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic        s_err_o,
  output logic        m_en_o,
  output logic        m_wr_o,
  output logic [27:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  gap_cnt_reg;
  logic        timeout_hit;
  logic [31:0] resp_dat;
  logic        wr_reg;
  logic [27:0] adr_reg;
  logic [31:0] wdat_reg;
  logic [31:0] rdat_reg;

`ifdef TURF_GEN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] to_cnt_reg;
  logic [15:0]   timeout_count;
  logic          err_reg;

  // An ack in the final allowed cycle takes priority over the abort.
  assign timeout_hit = (state_reg == ISSUE) && !m_ack_i && (to_cnt_reg == TW'(TIMEOUT - 1));
  assign resp_dat    = timeout_hit ? TIMEOUT_DATA : m_dat_i;
  assign s_err_o     = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if ((state_reg == ISSUE) && !m_ack_i && !timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end else begin
      to_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (timeout_hit && (timeout_count != 16'hFFFF)) begin
        timeout_count <= timeout_count + 16'd1;
      end
      if ((state_reg == ISSUE) && (m_ack_i || timeout_hit)) begin
        err_reg <= timeout_hit;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^{TIMEOUT_DATA, 32'(TIMEOUT)};
  assign timeout_hit = 1'b0;
  assign resp_dat    = m_dat_i;
  assign s_err_o     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (s_en_i) state_next = ISSUE;
      ISSUE:   if (m_ack_i || timeout_hit) state_next = RESP;
      RESP:    state_next = (IDLE_GAP > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_en_o  = (state_reg == ISSUE);
    s_ack_o = (state_reg == RESP);
    busy_o  = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_reg <= '0;
    end else if (state_reg == GAP) begin
      gap_cnt_reg <= gap_cnt_reg + 4'd1;
    end else begin
      gap_cnt_reg <= '0;
    end
  end

  // Request is committed once latched; s_en_i is not looked at again until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg   <= 1'b0;
      adr_reg  <= '0;
      wdat_reg <= '0;
      rdat_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && s_en_i) begin
        wr_reg   <= s_wr_i;
        adr_reg  <= s_adr_i;
        wdat_reg <= s_dat_i;
      end
      if ((state_reg == ISSUE) && (m_ack_i || timeout_hit)) begin
        rdat_reg <= resp_dat;
      end
    end
  end

  assign m_wr_o  = wr_reg;
  assign m_adr_o = adr_reg;
  assign m_dat_o = wdat_reg;
  assign s_dat_o = rdat_reg;

endmodule

// File: tb/tb_turf_generic_seq.sv
// Directed bench for turf_generic_seq (TIMEOUT=8, IDLE_GAP=2) with a timestamp-based reference model.
module tb_turf_generic_seq;

  localparam int          TIMEOUT  = 8;
  localparam int          IDLE_GAP = 2;
  localparam logic [31:0] TO_DATA  = 32'hDEADBEEF;
`ifdef TURF_GEN_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_en = 1'b0;
  logic        s_wr = 1'b0;
  logic [27:0] s_adr = '0;
  logic [31:0] s_wdat = '0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdat = '0;
  logic        s_ack, s_err, m_en, m_wr, busy;
  logic [31:0] s_dat, m_dat;
  logic [27:0] m_adr;

  int checks = 0;
  int errors = 0;

  turf_generic_seq #(.TIMEOUT(TIMEOUT), .IDLE_GAP(IDLE_GAP), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_en_i(s_en), .s_wr_i(s_wr), .s_adr_i(s_adr), .s_dat_i(s_wdat),
    .s_ack_o(s_ack), .s_dat_o(s_dat), .s_err_o(s_err),
    .m_en_o(m_en), .m_wr_o(m_wr), .m_adr_o(m_adr), .m_dat_o(m_dat),
    .m_ack_i(m_ack), .m_dat_i(m_rdat), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by when its bus phase started, when its
  // response cycle is, and from which cycle a new request may be accepted.
  int          cyc = 0;
  bit          open = 1'b0;
  int          en_start = 0;
  int          resp_cyc = -1;
  int          idle_from = 0;
  logic        e_wr = 1'b0;
  logic [27:0] e_adr = '0;
  logic [31:0] e_wdat = '0;
  logic [31:0] e_sdat = '0;
  logic        e_serr = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        open = 1'b0; resp_cyc = -1; idle_from = 0;
        e_wr = 1'b0; e_adr = '0; e_wdat = '0; e_sdat = '0; e_serr = 1'b0;
      end else if (!open && cyc >= idle_from && s_en) begin
        open = 1'b1; en_start = cyc + 1;
        e_wr = s_wr; e_adr = s_adr; e_wdat = s_wdat;
      end else if (open && cyc >= en_start) begin
        if (m_ack || (TO_EN && (cyc - en_start == TIMEOUT - 1))) begin
          open      = 1'b0;
          resp_cyc  = cyc + 1;
          idle_from = cyc + 2 + IDLE_GAP;
          e_sdat    = m_ack ? m_rdat : TO_DATA;
          e_serr    = !m_ack;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_en", m_en, 0);   chk("rst_s_ack", s_ack, 0); chk("rst_busy", busy, 0);
      chk("rst_s_err", s_err, 0); chk("rst_s_dat", s_dat, 0); chk("rst_m_wr", m_wr, 0);
      chk("rst_m_adr", m_adr, 0); chk("rst_m_dat", m_dat, 0);
    end else begin
      chk("m_en", m_en, open && cyc >= en_start);
      chk("s_ack", s_ack, cyc == resp_cyc);
      chk("busy", busy, open || cyc < idle_from);
      chk("s_dat", s_dat, e_sdat);
      chk("s_err", s_err, e_serr);
      chk("m_wr", m_wr, e_wr);
      chk("m_adr", m_adr, e_adr);
      chk("m_dat", m_dat, e_wdat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_at: ISSUE cycle (1-based) in which the bus acks; 0 = never.
  task automatic run_txn(input logic wr, input logic [27:0] adr, input logic [31:0] wdat,
                         input int ack_at, input logic [31:0] rdat, input bit hold,
                         output int en_cnt, output int rise, output int ack_cyc,
                         output logic [31:0] got_dat, output logic got_err);
    s_en = 1'b1; s_wr = wr; s_adr = adr; s_wdat = wdat;
    en_cnt = 0; rise = -1; ack_cyc = -1; got_dat = 'x; got_err = 1'bx;
    for (int i = 0; i < 100; i++) begin
      step();
      m_ack = 1'b0;
      if (s_ack) begin
        ack_cyc = cyc; got_dat = s_dat; got_err = s_err;
        break;
      end
      if (m_en) begin
        en_cnt++;
        if (en_cnt == 1) rise = cyc;
        if (en_cnt == ack_at) begin
          m_ack = 1'b1; m_rdat = rdat;
        end
      end
    end
    if (!hold) s_en = 1'b0;
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL txn_no_ack: got no s_ack_o within 100 cycles, required one (adr=%h)", adr);
    end
    $display("txn wr=%0d adr=%h en_cycles=%0d rise=%0d ack=%0d s_dat=%h err=%0d",
             wr, adr, en_cnt, rise, ack_cyc, got_dat, got_err);
  endtask

  initial begin
    int n, r, a, r2, a2;
    logic [31:0] d;
    logic e;

    repeat (3) step();
    chk("reset_m_en", m_en, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Read, ack in third ISSUE cycle
    run_txn(1'b0, 28'h0000123, 32'h0, 3, 32'hCAFEF00D, 1'b0, n, r, a, d, e);
    chk("read_en_cycles", n, 3);
    chk("read_latency", a - r, 3);
    chk("read_data", d, 32'hCAFEF00D);
    chk("read_err", e, 0);

    // Write, then IDLE_GAP busy cycles in GAP
    run_txn(1'b1, 28'h0000456, 32'h12345678, 2, 32'hA5A5A5A5, 1'b0, n, r, a, d, e);
    chk("write_en_cycles", n, 2);
    chk("write_err", e, 0);
    for (int i = 0; i < IDLE_GAP; i++) begin
      step();
      chk("write_gap_busy", busy, 1);
    end
    step();
    chk("write_idle_busy", busy, 0);

`ifdef TURF_GEN_SEQ_TIMEOUT_EN
    // Bus never acks: abort after TIMEOUT cycles, then a late stray ack
    run_txn(1'b0, 28'h0000789, 32'h0, 0, 32'h0, 1'b0, n, r, a, d, e);
    chk("to_en_cycles", n, 8);
    chk("to_data", d, 32'hDEADBEEF);
    chk("to_err", e, 1);
    chk("to_count", dut.timeout_count, 1);
    step();
    step();
    m_ack = 1'b1; m_rdat = 32'h77777777;
    chk("stray_ack_no_s_ack", s_ack, 0);
    step();
    m_ack = 1'b0;
    chk("stray_ack_s_dat", s_dat, 32'hDEADBEEF);
    step();
`else
    // Without the abort path ISSUE waits well beyond TIMEOUT
    run_txn(1'b0, 28'h0000789, 32'h0, 20, 32'h11112222, 1'b0, n, r, a, d, e);
    chk("wait_en_cycles", n, 20);
    chk("wait_data", d, 32'h11112222);
    chk("wait_err", e, 0);
`endif

    // Ack on the last cycle before the abort would fire
    run_txn(1'b0, 28'h0000ABC, 32'h0, 8, 32'h600DF00D, 1'b0, n, r, a, d, e);
    chk("lastack_en_cycles", n, 8);
    chk("lastack_data", d, 32'h600DF00D);
    chk("lastack_err", e, 0);

    // Back-to-back with s_en held: accepted IDLE_GAP+1 cycles after s_ack, m_en one cycle later
    run_txn(1'b0, 28'h0000111, 32'h0, 1, 32'h01010101, 1'b1, n, r, a, d, e);
    run_txn(1'b1, 28'h0000222, 32'hBEEF0002, 1, 32'h02020202, 1'b0, n, r2, a2, d, e);
    chk("b2b_rise_gap", r2 - a, 4);
    chk("b2b_second_data", d, 32'h02020202);

    // Reset mid-ISSUE discards the transaction
    s_en = 1'b1; s_wr = 1'b0; s_adr = 28'h0ABCDEF;
    for (int i = 0; i < 20 && !m_en; i++) step();
    chk("midrst_m_en_seen", m_en, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_m_en", m_en, 0);
    chk("midrst_busy", busy, 0);
    s_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_s_ack", s_ack, 0);
    end
    rst_n = 1'b1;
`ifdef TURF_GEN_SEQ_TIMEOUT_EN
    chk("to_count_cleared", dut.timeout_count, 0);
`endif
    step();
    run_txn(1'b0, 28'h0000321, 32'h0, 2, 32'h55AA55AA, 1'b0, n, r, a, d, e);
    chk("postrst_en_cycles", n, 2);
    chk("postrst_data", d, 32'h55AA55AA);
    chk("postrst_err", e, 0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
